// File: rtl/zx_spi_frame_rx.sv
// SPI slave frame receiver: synchronises the MCU SPI lines and commits whole frames
// into the keyboard/mouse/Kempston/config registers. Optional macro: ZX_SPI_FRAME_PARITY_EN.
module zx_spi_frame_rx #(
    parameter int unsigned KBD_BITS    = 40,
    parameter int unsigned MOUSE_BITS  = 24,
    parameter int unsigned KMPST_BITS  = 8,
    parameter int unsigned CFG_BITS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  CLK14M,
    input  logic                  RESET,
    input  logic                  SPI_SCK,
    input  logic                  SPI_NSS,
    input  logic                  SPI_MOSI,
    input  logic [1:0]            SPI_A,
    output logic [KBD_BITS-1:0]   KBD_MATRIX,
    output logic [MOUSE_BITS-1:0] MOUSE_DATA,
    output logic [KMPST_BITS-1:0] KMPST_DATA,
    output logic [CFG_BITS-1:0]   CONFIG,
    output logic                  FRAME_STB,
    output logic                  FRAME_ERR,
    output logic [1:0]            FRAME_ADR
);

`ifdef ZX_SPI_FRAME_PARITY_EN
    localparam int unsigned PAR = 1;
`else
    localparam int unsigned PAR = 0;
`endif
    localparam int unsigned SHIFT_W = KBD_BITS + PAR;
    localparam int unsigned CNT_W   = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic [1:0] ADR_CFG   = 2'b00;
    localparam logic [1:0] ADR_MOUSE = 2'b01;
    localparam logic [1:0] ADR_KMPST = 2'b10;
    localparam logic [1:0] ADR_KBD   = 2'b11;

    logic [SYNC_STAGES-1:0] sck_sync, nss_sync, mosi_sync, a0_sync, a1_sync;
    logic                   sck_d;
    logic                   sck_s, nss_s, mosi_s, sck_rise;
    logic [1:0]             a_s;

    logic [1:0]             state_q, state_d;
    logic                   armed_q, armed_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [1:0]             adr_q, adr_d;

    logic [KBD_BITS-1:0]    kbd_d;
    logic [MOUSE_BITS-1:0]  mouse_d;
    logic [KMPST_BITS-1:0]  kmpst_d;
    logic [CFG_BITS-1:0]    cfg_d;
    logic                   stb_d, err_d;
    logic [1:0]             frame_adr_d;
    logic                   len_ok, parity_ok;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign nss_s    = nss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign a_s      = {a1_sync[SYNC_STAGES-1], a0_sync[SYNC_STAGES-1]};
    assign sck_rise = sck_s & ~sck_d;

    // Input synchronisers and SCK edge history
    always_ff @(posedge CLK14M) begin
        if (RESET) begin
            sck_sync  <= '0;
            nss_sync  <= '0;
            mosi_sync <= '0;
            a0_sync   <= '0;
            a1_sync   <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], SPI_NSS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            a0_sync   <= {a0_sync[SYNC_STAGES-2:0], SPI_A[0]};
            a1_sync   <= {a1_sync[SYNC_STAGES-2:0], SPI_A[1]};
            sck_d     <= sck_s;
        end
    end

    // Frame length check against the target latched at frame start
    always_comb begin
        len_ok = 1'b0;
        case (adr_q)
            ADR_CFG:   len_ok = (cnt_q == CNT_W'(CFG_BITS + PAR));
            ADR_MOUSE: len_ok = (cnt_q == CNT_W'(MOUSE_BITS + PAR));
            ADR_KMPST: len_ok = (cnt_q == CNT_W'(KMPST_BITS + PAR));
            default:   len_ok = (cnt_q == CNT_W'(KBD_BITS + PAR));
        endcase
    end

`ifdef ZX_SPI_FRAME_PARITY_EN
    // Odd parity over data plus trailing parity bit
    always_comb begin
        parity_ok = 1'b0;
        case (adr_q)
            ADR_CFG:   parity_ok = ^shift_q[CFG_BITS:0];
            ADR_MOUSE: parity_ok = ^shift_q[MOUSE_BITS:0];
            ADR_KMPST: parity_ok = ^shift_q[KMPST_BITS:0];
            default:   parity_ok = ^shift_q[KBD_BITS:0];
        endcase
    end
`else
    assign parity_ok = 1'b1;
`endif

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q | nss_s;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        adr_d       = adr_q;
        kbd_d       = KBD_MATRIX;
        mouse_d     = MOUSE_DATA;
        kmpst_d     = KMPST_DATA;
        cfg_d       = CONFIG;
        stb_d       = 1'b0;
        err_d       = 1'b0;
        frame_adr_d = FRAME_ADR;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !nss_s) begin
                    adr_d   = a_s;
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // NSS release wins over a coincident SCK edge
                if (nss_s) begin
                    state_d = ST_CHECK;
                end else if (sck_rise) begin
                    shift_d = {shift_q[SHIFT_W-2:0], mosi_s};
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                frame_adr_d = adr_q;
                state_d     = ST_IDLE;
                if (len_ok && parity_ok) begin
                    stb_d = 1'b1;
                    case (adr_q)
                        ADR_CFG:   cfg_d   = shift_q[CFG_BITS-1+PAR:PAR];
                        ADR_MOUSE: mouse_d = shift_q[MOUSE_BITS-1+PAR:PAR];
                        ADR_KMPST: kmpst_d = shift_q[KMPST_BITS-1+PAR:PAR];
                        default:   kbd_d   = ~shift_q[KBD_BITS-1+PAR:PAR];
                    endcase
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK14M) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            adr_q      <= '0;
            KBD_MATRIX <= '0;
            MOUSE_DATA <= '0;
            KMPST_DATA <= '0;
            CONFIG     <= '0;
            FRAME_STB  <= 1'b0;
            FRAME_ERR  <= 1'b0;
            FRAME_ADR  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            adr_q      <= adr_d;
            KBD_MATRIX <= kbd_d;
            MOUSE_DATA <= mouse_d;
            KMPST_DATA <= kmpst_d;
            CONFIG     <= cfg_d;
            FRAME_STB  <= stb_d;
            FRAME_ERR  <= err_d;
            FRAME_ADR  <= frame_adr_d;
        end
    end

endmodule
